imem_loader: RTL and testbench

Boot-time instruction-memory writer for the single-cycle MIPS core. It takes a framed byte stream from the serial receiver, assembles big-endian 32-bit instruction words and writes them into the instruction RAM that the fetch/decode stage reads through its address/data port. While a load is in progress it holds the CPU. It releases the CPU only after the image checksum verifies.

---
 rtl/imem_loader.sv | 177 +++++++++++++++++
 tb/tb_imem_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction RAM.
// Receives a framed byte stream (LEN_HI, LEN_LO, N*4 data bytes, CSUM),
// assembles big-endian 32-bit words, writes them one per WRITE cycle and
// holds the CPU until the XOR checksum of the data bytes verifies.
//
// Handshake: a byte is consumed on any rising edge where rx_valid and
// rx_ready are both high; rx_ready depends on the current state only,
// so the sender may hold rx_valid/rx_data steady until it sees rx_ready.
module imem_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] words_loaded,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_CSUM   = 3'd5
    } state_t;

    // Largest legal word count: the full RAM capacity, capped at what a
    // 16-bit length field can express.
    localparam logic [16:0] MAX_WORDS =
        (ADDR_WIDTH >= 16) ? 17'h10000 : 17'(1 << ADDR_WIDTH);

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic        len_too_big;
    logic        len_zero;
    logic [15:0] len_q;
    logic [23:0] word_q;
    logic [1:0]  byte_cnt;
    logic [7:0]  csum_q;

    // Length check on the byte being accepted in LEN_LO.
    assign len_too_big = ({1'b0, len_q[15:8], rx_data} > MAX_WORDS);
    assign len_zero    = ({len_q[15:8], rx_data} == 16'd0);
    assign state_dbg   = state;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (accept) state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept) begin
                    if (len_too_big)   state_next = S_IDLE;
                    else if (len_zero) state_next = S_CSUM;
                    else               state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && byte_cnt == 2'd3) state_next = S_WRITE;
            end
            S_WRITE: begin
                if (words_loaded + 16'd1 == len_q) state_next = S_CSUM;
                else                               state_next = S_DATA;
            end
            S_CSUM: begin
                if (accept) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode: rx_ready comes from the current state alone.
    always_comb begin
        rx_ready = 1'b0;
        case (state)
            S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM: rx_ready = 1'b1;
            default:                            rx_ready = 1'b0;
        endcase
        accept = rx_ready & rx_valid;
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_wr       <= 1'b0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= 32'd0;
            cpu_hold     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= 16'd0;
            len_q        <= 16'd0;
            word_q       <= 24'd0;
            byte_cnt     <= 2'd0;
            csum_q       <= 8'd0;
        end else begin
            mem_wr <= (state_next == S_WRITE);
            busy   <= (state_next != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        done         <= 1'b0;
                        err          <= 1'b0;
                        words_loaded <= 16'd0;
                        csum_q       <= 8'd0;
                        byte_cnt     <= 2'd0;
                        cpu_hold     <= 1'b1;
                    end
                end
                S_LEN_HI: begin
                    if (accept) len_q[15:8] <= rx_data;
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len_q[7:0] <= rx_data;
                        if (len_too_big) err <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        word_q   <= {word_q[15:0], rx_data};
                        csum_q   <= csum_q ^ rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        // Present the finished word for the WRITE cycle.
                        if (byte_cnt == 2'd3) begin
                            mem_wdata <= {word_q, rx_data};
                            mem_addr  <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
                        end
                    end
                end
                S_WRITE: begin
                    words_loaded <= words_loaded + 16'd1;
                end
                S_CSUM: begin
                    if (accept) begin
                        if (rx_data == csum_q) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frames are built from byte lists; the expected
// writes and final status come from a frame-level model and are checked
// by a monitor that pops one expected write per mem_wr strobe.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          CAP  = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;
    logic [2:0]  state_dbg;

    logic [63:0] exp_q[$];
    logic [7:0]  data_q[$];
    int          n_checks = 0;
    int          n_pass = 0;

    imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
        .words_loaded(words_loaded), .state_dbg(state_dbg)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    // monitor / scoreboard: one expected write per mem_wr cycle
    always @(negedge clk) begin
        if (reset && mem_wr) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got addr %h data %h, no write expected",
                         mem_addr, mem_wdata);
            end else begin
                check("write", {mem_addr, mem_wdata}, exp_q.pop_front());
            end
        end
    end

    // driver: called at a negedge, returns at the negedge after the accept
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        if (gap == 1) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end else if (gap == 2) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (!rx_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            n_checks++;
            $display("FAIL rx_ready_timeout: got rx_ready 0 for 20 cycles, expected 1");
            rx_valid = 1'b0;
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("hold_after_start", cpu_hold, 1);
        check("done_cleared", done, 0);
        check("err_cleared", err, 0);
        check("words_cleared", words_loaded, 0);
    endtask

    // One frame; data bytes come from data_q. Model derives expected
    // writes and end status from the frame contents.
    task automatic run_load(input logic [15:0] n, input logic [7:0] csum,
                            input int gap, input bit poke_start);
        logic [7:0] xs;
        bit         ok;
        xs = 8'd0;
        if (int'(n) <= CAP) begin
            for (int i = 0; i < int'(n); i++) begin
                exp_q.push_back({BASE + 32'(4 * i), data_q[4*i], data_q[4*i+1],
                                 data_q[4*i+2], data_q[4*i+3]});
                for (int k = 0; k < 4; k++) xs ^= data_q[4*i+k];
            end
        end
        ok = (xs == csum);
        pulse_start();
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
        if (int'(n) > CAP) begin
            rx_valid = 1'b0;
            check("lenerr_err", err, 1);
            check("lenerr_done", done, 0);
            check("lenerr_busy", busy, 0);
            check("lenerr_rx_ready", rx_ready, 0);
            check("lenerr_words", words_loaded, 0);
            check("lenerr_hold", cpu_hold, 1);
            repeat (4) @(negedge clk);
            check("lenerr_rx_ready_later", rx_ready, 0);
            return;
        end
        for (int i = 0; i < 4 * int'(n); i++) begin
            if (poke_start && i == 2) start = 1'b1;
            send_byte(data_q[i], gap);
            start = 1'b0;
        end
        send_byte(csum, gap);
        rx_valid = 1'b0;
        check("end_done", done, ok ? 1 : 0);
        check("end_err", err, ok ? 0 : 1);
        check("end_hold", cpu_hold, ok ? 0 : 1);
        check("end_busy", busy, 0);
        check("end_words", words_loaded, n);
        check("writes_pending", exp_q.size(), 0);
    endtask

    task automatic fill_random(input int n);
        data_q.delete();
        for (int i = 0; i < 4 * n; i++) data_q.push_back(8'($urandom_range(0, 255)));
    endtask

    function automatic logic [7:0] xor_all();
        logic [7:0] x = 8'd0;
        foreach (data_q[i]) x ^= data_q[i];
        return x;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // clock/reset
        repeat (3) @(negedge clk);
        check("rst_rx_ready", rx_ready, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_addr", mem_addr, BASE);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_hold", cpu_hold, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_words", words_loaded, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // directed frame, good and bad checksum
        data_q = '{8'h3C, 8'h01, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00};
        run_load(16'd2, 8'h1B, 0, 1'b0);
        run_load(16'd2, 8'h1A, 0, 1'b0);

        // empty image
        data_q.delete();
        run_load(16'd0, 8'h00, 0, 1'b0);

        // one past capacity, then a clean restart
        run_load(16'd257, 8'h00, 0, 1'b0);

        // valid toggling with start pulsed mid-DATA
        data_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_load(16'd1, 8'h22, 1, 1'b1);

        // reset after the 2nd data byte of word 0
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h5A, 0);
        reset = 1'b0;
        rx_valid = 1'b0;
        #1;
        check("abort_hold", cpu_hold, 0);
        check("abort_busy", busy, 0);
        check("abort_mem_wr", mem_wr, 0);
        check("abort_rx_ready", rx_ready, 0);
        check("abort_words", words_loaded, 0);
        check("abort_addr", mem_addr, BASE);
        check("abort_wdata", mem_wdata, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check("after_abort_busy", busy, 0);
        check("after_abort_hold", cpu_hold, 0);

        // randomized frames
        for (int r = 0; r < 8; r++) begin
            int n;
            logic [7:0] cs;
            n = $urandom_range(1, 8);
            fill_random(n);
            cs = xor_all();
            if ($urandom_range(0, 3) == 0) cs = cs ^ 8'(1 << $urandom_range(0, 7));
            run_load(16'(n), cs, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // full capacity
        fill_random(CAP);
        run_load(16'(CAP), xor_all(), 0, 1'b0);

        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
